ref_sched: RTL and testbench

REF_SCHED -- requirements
Module: ref_sched

---
 rtl/ref_sched_pkg.sv | 14 +
 rtl/ref_tick.sv | 28 ++
 rtl/ref_sched.sv | 99 +++++++++
 tb/tb_ref_sched.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/ref_sched_pkg.sv
// Shared types and constants for the refresh scheduler.
// The state encoding places RefReq in bit 0 and RefUrgent in bit 1.
package ref_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PEND = 2'b01,
    URG  = 2'b11
  } state_t;

  localparam int DEBT_W = 3;
  localparam logic [DEBT_W-1:0] DEBT_MAX = 3'd7;

endpackage

// File: rtl/ref_tick.sv
// Refresh prescaler: free-running 0..REF_PERIOD-1 counter.
// Tick strobes for the single cycle in which the count sits at its last value.
module ref_tick #(
  parameter int REF_PERIOD = 250
) (
  input  logic CLK,
  input  logic nRST,
  output logic Tick
);

  localparam int CNT_W = (REF_PERIOD > 1) ? $clog2(REF_PERIOD) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(REF_PERIOD - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign Tick = (cnt == LAST);

endmodule

// File: rtl/ref_sched.sv
// DRAM refresh scheduler: tracks owed refreshes (debt), how long the oldest has waited,
// and raises RefReq / RefUrgent from registered state one cycle after each Tick or Ack.
module ref_sched
  import ref_sched_pkg::*;
#(
  parameter int REF_PERIOD  = 250,
  parameter int URGENT_DEBT = 2,
  parameter int AGE_MAX     = 125
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              RefAck,
  output logic              RefReq,
  output logic              RefUrgent,
  output logic [DEBT_W-1:0] RefDebt,
  output logic              RefErr
);

  localparam int AGE_W = $clog2(AGE_MAX + 1);
  localparam logic [AGE_W-1:0]  AGE_LIM = AGE_W'(AGE_MAX);
  localparam logic [DEBT_W-1:0] URG_LIM = DEBT_W'(URGENT_DEBT);

  logic              tick;
  logic              ack_q;
  logic              armed;
  logic              ack;
  logic [DEBT_W-1:0] debt;
  logic [DEBT_W-1:0] debt_nxt;
  logic [AGE_W-1:0]  age;
  logic [AGE_W-1:0]  age_nxt;
  logic              aged;
  logic              err_set;
  state_t            state;
  state_t            state_nxt;

  ref_tick #(
    .REF_PERIOD(REF_PERIOD)
  ) u_tick (
    .CLK (CLK),
    .nRST(nRST),
    .Tick(tick)
  );

  // armed stays low until RefAck has been seen low, so a level held across reset never counts
  assign ack = RefAck & ~ack_q & armed;

  always_comb begin
    debt_nxt = debt;
    err_set  = 1'b0;
    if (tick && !ack) begin
      if (debt == DEBT_MAX) err_set = 1'b1;
      else                  debt_nxt = debt + 1'b1;
    end else if (ack && !tick) begin
      if (debt == '0) err_set = 1'b1;
      else            debt_nxt = debt - 1'b1;
    end

    age_nxt = age;
    if (debt_nxt == '0 || ack) begin
      age_nxt = '0;
    end else if (debt != '0 && age != AGE_LIM) begin
      age_nxt = age + 1'b1;
    end

    // an Ack restarts the wait, so it also cancels age-based urgency this cycle
    aged = !ack && (age == AGE_LIM);

    if (debt_nxt == '0) begin
      state_nxt = IDLE;
    end else if (debt_nxt >= URG_LIM || aged) begin
      state_nxt = URG;
    end else begin
      state_nxt = PEND;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      ack_q  <= 1'b0;
      armed  <= 1'b0;
      debt   <= '0;
      age    <= '0;
      RefErr <= 1'b0;
      state  <= IDLE;
    end else begin
      ack_q <= RefAck;
      if (!RefAck) armed <= 1'b1;
      debt  <= debt_nxt;
      age   <= age_nxt;
      if (err_set) RefErr <= 1'b1;
      state <= state_nxt;
    end
  end

  assign RefReq    = state[0];
  assign RefUrgent = state[1];
  assign RefDebt   = debt;

endmodule

// File: tb/tb_ref_sched.sv
// Directed bench for ref_sched: an edge-counting reference model checked every cycle,
// plus hand-computed literal checkpoints along a single long scenario.
module tb_ref_sched;

  localparam int P    = 250;
  localparam int UD   = 2;
  localparam int AMAX = 125;

  logic       CLK    = 1'b0;
  logic       nRST   = 1'b0;
  logic       RefAck = 1'b0;
  logic       RefReq;
  logic       RefUrgent;
  logic [2:0] RefDebt;
  logic       RefErr;

  int checks = 0;
  int errors = 0;

  ref_sched #(
    .REF_PERIOD (P),
    .URGENT_DEBT(UD),
    .AGE_MAX    (AMAX)
  ) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .RefAck   (RefAck),
    .RefReq   (RefReq),
    .RefUrgent(RefUrgent),
    .RefDebt  (RefDebt),
    .RefErr   (RefErr)
  );

  initial forever #5 CLK = ~CLK;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: counts edges since reset; age is measured as edges elapsed
  // since the current owed period (or the last Ack) began.
  int m_cnt = 0, m_debt = 0, m_edge = 0, m_start = 0;
  bit m_err = 0, m_seen_low = 0, m_prev = 0, m_aged = 0, m_tick = 0, m_ack = 0;
  int old_debt;

  initial forever begin
    @(posedge CLK or negedge nRST);
    if (!nRST) begin
      m_cnt = 0; m_debt = 0; m_edge = 0; m_start = 0;
      m_err = 0; m_seen_low = 0; m_prev = 0; m_aged = 0;
    end else begin
      m_edge++;
      m_tick = (m_cnt == P - 1);
      m_cnt  = (m_cnt + 1) % P;
      m_ack  = RefAck && !m_prev && m_seen_low;
      if (!RefAck) m_seen_low = 1;
      m_prev = RefAck;
      old_debt = m_debt;
      if (m_tick && !m_ack) begin
        if (m_debt == 7) m_err = 1; else m_debt++;
      end else if (m_ack && !m_tick) begin
        if (m_debt == 0) m_err = 1; else m_debt--;
      end
      if (m_ack || (old_debt == 0 && m_debt != 0)) m_start = m_edge;
      m_aged = (m_debt != 0) && !m_ack && (m_edge - m_start >= AMAX + 1);
    end
  end

  initial forever begin
    @(negedge CLK);
    chk("model_req", RefReq, (m_debt > 0) ? 1 : 0);
    chk("model_urg", RefUrgent, (m_debt >= UD || m_aged) ? 1 : 0);
    chk("model_debt", RefDebt, m_debt);
    chk("model_err", RefErr, m_err);
  end

  initial begin
    repeat (3) @(negedge CLK);
    chk("rst_req", RefReq, 0);
    chk("rst_urg", RefUrgent, 0);
    chk("rst_debt", RefDebt, 0);
    chk("rst_err", RefErr, 0);
    nRST = 1'b1;

    repeat (249) @(negedge CLK);
    chk("pre_tick_debt", RefDebt, 0);
    @(negedge CLK);
    chk("tick1_debt", RefDebt, 1);
    chk("tick1_req", RefReq, 1);
    chk("tick1_urg", RefUrgent, 0);

    repeat (125) @(negedge CLK);
    chk("age_pre_urg", RefUrgent, 0);
    @(negedge CLK);
    chk("age_urg", RefUrgent, 1);

    repeat (124) @(negedge CLK);
    chk("tick2_debt", RefDebt, 2);
    chk("tick2_urg", RefUrgent, 1);

    RefAck = 1'b1;
    @(negedge CLK);
    chk("ack_debt", RefDebt, 1);
    chk("ack_urg", RefUrgent, 0);
    @(negedge CLK);
    RefAck = 1'b0;
    chk("long_ack_debt", RefDebt, 1);

    repeat (247) @(negedge CLK);
    RefAck = 1'b1;
    @(negedge CLK);
    chk("tick_ack_debt", RefDebt, 1);
    chk("tick_ack_err", RefErr, 0);
    RefAck = 1'b0;
    @(negedge CLK);
    RefAck = 1'b1;
    @(negedge CLK);
    RefAck = 1'b0;
    chk("drain_debt", RefDebt, 0);
    chk("drain_req", RefReq, 0);

    @(negedge CLK);
    RefAck = 1'b1;
    @(negedge CLK);
    RefAck = 1'b0;
    chk("zero_ack_err", RefErr, 1);
    chk("zero_ack_debt", RefDebt, 0);

    repeat (2750 - 754) @(negedge CLK);
    chk("sat_debt", RefDebt, 7);
    chk("sat_err", RefErr, 1);
    chk("sat_urg", RefUrgent, 1);

    for (int i = 0; i < 4; i++) begin
      RefAck = 1'b1;
      @(negedge CLK);
      RefAck = 1'b0;
      @(negedge CLK);
    end
    chk("debt3", RefDebt, 3);

    RefAck = 1'b1;
    #2 nRST = 1'b0;
    #1;
    chk("async_rst_req", RefReq, 0);
    chk("async_rst_urg", RefUrgent, 0);
    chk("async_rst_debt", RefDebt, 0);
    chk("async_rst_err", RefErr, 0);
    repeat (2) @(negedge CLK);
    nRST = 1'b1;
    repeat (3) @(negedge CLK);
    chk("held_ack_err", RefErr, 0);
    chk("held_ack_debt", RefDebt, 0);
    RefAck = 1'b0;
    @(negedge CLK);
    RefAck = 1'b1;
    @(negedge CLK);
    chk("re_rise_err", RefErr, 1);
    RefAck = 1'b0;
    repeat (2) @(negedge CLK);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
